alu_control_seq: RTL and testbench

- Parametrised, registered successor to the 8-bit MIPS ALU control decoder.
- Takes a decoded main-control ALU op plus function field. Emits ALU control codes on a valid/ready stream to the execute stage.
- Adds multi-cycle mode: a shift by N is issued as N single-bit shift beats.
- Sits between the main control unit and the ALU, and takes part in pipeline stall and flush.

---
 rtl/alu_control_seq.sv | 127 ++++++++++++
 tb/tb_alu_control_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// Registered ALU control sequencer: decodes main-control op/funct into ALU codes on a
// valid/ready stream, expanding shift-by-N into N single-bit shift beats.
//
// state  | meaning
// IDLE   | no beat on the output, ready for a command
// SINGLE | one-beat command on the output (pass-through, add, sub, zero shift)
// ITER   | multi-beat shift on the output, counter holds remaining beats
module alu_control_seq #(
    parameter int                FUNCT_W  = 3,
    parameter int                CTRL_W   = 3,
    parameter int                MAX_ITER = 8,
    parameter int                CNT_W    = $clog2(MAX_ITER + 1),
    parameter logic [CTRL_W-1:0] ADD_CODE = 3'b001,
    parameter logic [CTRL_W-1:0] SUB_CODE = 3'b010,
    parameter logic [CTRL_W-1:0] SHL_CODE = 3'b110,
    parameter logic [CTRL_W-1:0] SHR_CODE = 3'b111,
    parameter logic [CTRL_W-1:0] NOP_CODE = 3'b000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [CNT_W-1:0]   shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               last,
    output logic               sat,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        ITER   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    state_t            r_state, w_state_nx;
    logic [CTRL_W-1:0] r_ctrl, w_ctrl_nx;
    logic              r_last, w_last_nx;
    logic              r_sat, w_sat_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [CNT_W-1:0]  w_cnt_load;
    logic              w_hs;

    assign out_valid  = (r_state != IDLE);
    assign busy       = (r_state != IDLE);
    assign alu_ctrl   = r_ctrl;
    assign last       = r_last;
    assign sat        = r_sat;
    assign w_hs       = out_valid && out_ready;
    assign w_cnt_load = (shamt > MAX_CNT) ? MAX_CNT : shamt;

    // A new command may only enter on the cycle the final beat of the current one retires.
    assign in_ready = !flush && ((r_state == IDLE) ||
                                 (r_state == SINGLE && out_ready) ||
                                 (r_state == ITER && out_ready && r_last));

    always_comb begin
        w_state_nx = r_state;
        w_ctrl_nx  = r_ctrl;
        w_last_nx  = r_last;
        w_sat_nx   = r_sat;
        w_cnt_nx   = r_cnt;
        if (flush) begin
            w_state_nx = IDLE;
            w_last_nx  = 1'b0;
            w_sat_nx   = 1'b0;
            w_cnt_nx   = '0;
        end else if (in_valid && in_ready) begin
            w_state_nx = SINGLE;
            w_last_nx  = 1'b1;
            w_sat_nx   = 1'b0;
            w_cnt_nx   = '0;
            case (alu_op)
                2'd0:    w_ctrl_nx = CTRL_W'(funct);
                2'd1:    w_ctrl_nx = ADD_CODE;
                2'd2:    w_ctrl_nx = SUB_CODE;
                default: begin
                    if (shamt == '0) begin
                        w_ctrl_nx = NOP_CODE;
                    end else begin
                        w_state_nx = ITER;
                        w_ctrl_nx  = funct[0] ? SHR_CODE : SHL_CODE;
                        w_cnt_nx   = w_cnt_load;
                        w_sat_nx   = (shamt > MAX_CNT);
                        w_last_nx  = (w_cnt_load == ONE);
                    end
                end
            endcase
        end else if (w_hs) begin
            if (r_state == ITER && !r_last) begin
                w_cnt_nx  = r_cnt - ONE;
                w_last_nx = (r_cnt == TWO);
            end else begin
                w_state_nx = IDLE;
                w_last_nx  = 1'b0;
                w_sat_nx   = 1'b0;
                w_cnt_nx   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ctrl  <= '0;
            r_last  <= 1'b0;
            r_sat   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ctrl  <= w_ctrl_nx;
            r_last  <= w_last_nx;
            r_sat   <= w_sat_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: vector table, hand-written corner sequences,
// and randomized traffic checked against a beat-queue reference model.
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [2:0] funct;
    logic [3:0] shamt;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] alu_ctrl;
    logic       last;
    logic       sat;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_control_seq dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .shamt(shamt), .out_valid(out_valid),
        .out_ready(out_ready), .alu_ctrl(alu_ctrl), .last(last), .sat(sat), .busy(busy)
    );

    typedef struct {
        logic [1:0] op;
        logic [2:0] fn;
        logic [3:0] sh;
        logic [2:0] ctrl;
        logic       sat;
        int         beats;
    } vec_t;

    typedef struct packed {
        logic [2:0] ctrl;
        logic       last;
        logic       sat;
    } beat_t;

    vec_t  tbl[10];
    beat_t q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [2:0] fn, input logic [3:0] sh,
                                input logic [2:0] ctrl, input logic s, input int beats);
        vec_t v;
        v.op = op; v.fn = fn; v.sh = sh; v.ctrl = ctrl; v.sat = s; v.beats = beats;
        return v;
    endfunction

    // Reference: a command expands into a list of expected beats.
    task automatic push_cmd(input logic [1:0] op, input logic [2:0] fn, input logic [3:0] sh);
        beat_t b;
        int    n;
        b.sat = 1'b0;
        b.last = 1'b1;
        if (op == 2'd0) begin
            b.ctrl = fn; q.push_back(b);
        end else if (op == 2'd1) begin
            b.ctrl = 3'b001; q.push_back(b);
        end else if (op == 2'd2) begin
            b.ctrl = 3'b010; q.push_back(b);
        end else if (sh == 0) begin
            b.ctrl = 3'b000; q.push_back(b);
        end else begin
            n = (sh > 8) ? 8 : int'(sh);
            b.ctrl = fn[0] ? 3'b111 : 3'b110;
            b.sat = (sh > 8);
            for (int i = 0; i < n; i++) begin
                b.last = (i == n - 1);
                q.push_back(b);
            end
        end
    endtask

    initial begin
        bit [3:0] rdy_pat;
        bit [3:0] last_pat;
        bit [3:0] ir_pat;
        logic exp_ir;

        tbl[0] = mk(2'd0, 3'b011, 4'd0,  3'b011, 1'b0, 1);
        tbl[1] = mk(2'd0, 3'b110, 4'd7,  3'b110, 1'b0, 1);
        tbl[2] = mk(2'd1, 3'b101, 4'd3,  3'b001, 1'b0, 1);
        tbl[3] = mk(2'd2, 3'b000, 4'd0,  3'b010, 1'b0, 1);
        tbl[4] = mk(2'd3, 3'b000, 4'd0,  3'b000, 1'b0, 1);
        tbl[5] = mk(2'd3, 3'b000, 4'd3,  3'b110, 1'b0, 3);
        tbl[6] = mk(2'd3, 3'b001, 4'd8,  3'b111, 1'b0, 8);
        tbl[7] = mk(2'd3, 3'b001, 4'd9,  3'b111, 1'b1, 8);
        tbl[8] = mk(2'd3, 3'b011, 4'd15, 3'b111, 1'b1, 8);
        tbl[9] = mk(2'd3, 3'b110, 4'd1,  3'b110, 1'b0, 1);

        // Reset held with a command already presented
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; alu_op = 2'd0; funct = 3'b101;
        shamt = 4'd0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ctrl", alu_ctrl, 0);
        chk("rst_last", last, 0);
        chk("rst_sat", sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rst_first_valid", out_valid, 1);
        chk("rst_first_ctrl", alu_ctrl, 3'b101);
        chk("rst_first_last", last, 1);
        @(negedge clk);
        #1;
        chk("rst_first_done", out_valid, 0);

        // Vector table, one command at a time with the sink always ready
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            in_valid = 1'b1; alu_op = tbl[v].op; funct = tbl[v].fn; shamt = tbl[v].sh;
            out_ready = 1'b1;
            #1;
            chk("tbl_accept", in_ready, 1);
            for (int k = 0; k < tbl[v].beats; k++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                chk("tbl_valid", out_valid, 1);
                chk("tbl_ctrl", alu_ctrl, tbl[v].ctrl);
                chk("tbl_sat", sat, tbl[v].sat);
                chk("tbl_last", last, (k == tbl[v].beats - 1) ? 1 : 0);
            end
            @(negedge clk);
            #1;
            chk("tbl_beat_count", out_valid, 0);
        end

        // Back-to-back add then subtract, no idle gap
        @(negedge clk);
        in_valid = 1'b1; alu_op = 2'd1; out_ready = 1'b1;
        @(negedge clk);
        alu_op = 2'd2;
        #1;
        chk("b2b_add_ctrl", alu_ctrl, 3'b001);
        chk("b2b_add_last", last, 1);
        chk("b2b_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("b2b_sub_valid", out_valid, 1);
        chk("b2b_sub_ctrl", alu_ctrl, 3'b010);
        @(negedge clk);
        #1;
        chk("b2b_done", out_valid, 0);

        // Shift by 3 with a one-cycle stall on the second beat
        rdy_pat = 4'b1101; last_pat = 4'b1000; ir_pat = 4'b1000;
        @(negedge clk);
        in_valid = 1'b1; alu_op = 2'd3; funct = 3'b000; shamt = 4'd3; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = rdy_pat[k];
            #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_ctrl", alu_ctrl, 3'b110);
            chk("stall_last", last, last_pat[k]);
            chk("stall_in_ready", in_ready, ir_pat[k]);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("stall_done", out_valid, 0);

        // Flush on the second beat of a shift by 5 while a command waits
        @(negedge clk);
        in_valid = 1'b1; alu_op = 2'd3; funct = 3'b000; shamt = 4'd5;
        @(negedge clk);
        alu_op = 2'd1;
        #1;
        chk("flush_beat1_last", last, 0);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_sat", sat, 0);
        chk("flush_after_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("flush_next_valid", out_valid, 1);
        chk("flush_next_ctrl", alu_ctrl, 3'b001);
        @(negedge clk);

        // Asynchronous reset between edges in the middle of a saturated shift
        in_valid = 1'b1; alu_op = 2'd3; funct = 3'b001; shamt = 4'd15;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("arst_pre_sat", sat, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sat", sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();

        // Randomized traffic against the beat-queue model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            flush     = ($urandom_range(0, 24) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            alu_op    = 2'($urandom_range(0, 3));
            funct     = 3'($urandom_range(0, 7));
            shamt     = 4'($urandom_range(0, 15));
            #1;
            exp_ir = !flush && (q.size() == 0 || (q.size() == 1 && out_ready));
            chk("rnd_in_ready", in_ready, exp_ir);
            chk("rnd_valid", out_valid, (q.size() != 0) ? 1 : 0);
            chk("rnd_busy", busy, (q.size() != 0) ? 1 : 0);
            if (q.size() != 0) begin
                chk("rnd_ctrl", alu_ctrl, q[0].ctrl);
                chk("rnd_last", last, q[0].last);
                chk("rnd_sat", sat, q[0].sat);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (out_ready && q.size() != 0) void'(q.pop_front());
                if (in_valid && exp_ir) push_cmd(alu_op, funct, shamt);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
